frame_sequencer: RTL
====================

// Module: frame_sequencer
// PURPOSE
//  Frame-level controller for the bicubic filter datapath. It sits between the RIFFA 64-bit RX/TX channels and the filter.
//  - Accepts a header word with the source dimensions, then loads source pixels into the 4-bank byte RAM.
//  - Publishes the fill level (current_pixel_RAM) that throttles the filter.
//  - Clamps and packs the filter's 128x128 output pixels into TX words, then re-arms itself for the next frame.
// PARAMETERS
//  MAX_PIXELS  65536  largest accepted rows*cols
//  ADDR_W      14     bank address width; bank depth = MAX_PIXELS/4
//  OUT_DIM     128    output width = height; OUT_PIXELS = OUT_DIM*OUT_DIM
// PORTS
//  clock              in   1          system clock
//  reset              in   1          synchronous, active-high
//  rx_data            in   64         header word or 8 source pixels
//  rx_valid           in   1          rx_data valid
//  rx_ready           out  1          word accepted when rx_valid & rx_ready
//  rows, cols         out  32 s       latched header dimensions, to filter
//  info_valid         out  1          header latched, frame active
//  current_pixel_RAM  out  32 s       index of highest pixel written; -1 when none
//  ram_wr_en          out  1          bank write strobe, all 4 banks
//  ram_wr_addr        out  ADDR_W     bank address
//  ram_wr_data        out  8 x[0:3]   byte for bank b
//  filt_reset         out  1          resets filter counters
//  pixel_in           in   32 s       filter output pixel
//  pixel_valid        in   1          pixel_in valid, 1 cycle; no backpressure
//  tx_data            out  64         8 packed output pixels
//  tx_valid           out  1          FIFO head valid
//  tx_ready           in   1          pop when tx_valid & tx_ready
//  frame_done         out  1          1-cycle pulse at end of frame
//  hdr_error          out  1          sticky: rejected header
//  ovf_error          out  1          sticky: output pixel dropped
// BEHAVIOUR
//  Reset values
//  - All outputs are 0, except current_pixel_RAM = -1 and filt_reset = 1.
//  - All state, counters and the FIFO are cleared.
//  - A reset mid-frame discards the partial frame, with no frame_done.
//  State machine (S_HDR, S_LO, S_HI, S_DRAIN)
//  - S_HDR: rx_ready=1. Header format: rows = rx_data[31:0], cols = rx_data[63:32].
//    - Valid header (rows>=1, cols>=1, rows*cols<=MAX_PIXELS): latched; info_valid=1 next cycle; go to S_LO.
//    - Invalid header: hdr_error set, stay in S_HDR.
//  - S_LO: rx_ready=1. On accept:
//    - pixel p of the word = rx_data[8p+7:8p];
//    - next cycle: ram_wr_en=1, addr=a, data = pixels 0..3; go to S_HI.
//  - S_HI: rx_ready=0.
//    - This cycle: ram_wr_en=1, addr=a+1, data = pixels 4..7; a += 2.
//    - Go to S_LO, or to S_DRAIN once ceil(rows*cols/8) words have been taken.
//    - Padding bytes in the last word are written anyway.
//  - S_DRAIN: rx_ready=0; waits for the output side to finish.
//  Addressing and fill level
//  - Bank b at address a holds pixel 4a+b.
//  - current_pixel_RAM = 4*(addr+1)-1, updated the cycle after each bank write, then clamped to rows*cols-1.
//  Output side (runs in S_LO, S_HI and S_DRAIN)
//  - Clamp pixel_in to 0..255; pack pixel k of a word into bits [8k+7:8k].
//  - When the 8th pixel is packed, push the word into a 2-entry FIFO.
//  - If the FIFO is full when a word completes:
//    - the pack register holds the word;
//    - any further pixel is dropped and ovf_error is set.
//  - Push and pop in the same cycle on a full FIFO are legal.
//  Frame end
//  - Condition: OUT_PIXELS pixels received and the FIFO plus pack register are empty.
//  - frame_done=1 and filt_reset=1 for one cycle.
//  - info_valid->0, current_pixel_RAM->-1, state->S_HDR.
//  - Error flags persist.
//  - Pixels arriving outside the active-frame window (info_valid=0) are ignored.
// STRUCTURE
//  - Package img_ctrl_pkg: state enum seq_state_e, OUT_PIXELS constant, typedef pixel_t = logic [7:0].
//  - Sub-module tx_word_fifo: 2-entry 64-bit FIFO with valid/ready pop, push, full and empty.
// TESTING
//  1. Header rows=4, cols=8 -> next cycle rows=4, cols=8, info_valid=1, current_pixel_RAM=-1.
//  2. Word 0x0706050403020100:
//     -> addr 0 data {00,01,02,03}, then addr 1 data {04,05,06,07};
//     -> rx_ready=0 during S_HI; current_pixel_RAM goes 3 then 7.
//  3. Header rows=0, then rows=cols=512:
//     -> hdr_error=1, info_valid=0;
//     -> a following header rows=cols=16 is accepted.
//  4. pixel_in = -5, 300, 17, 0, 1, 2, 3, 255 -> tx_data = 0xFF03020100_11FF00, tx_valid=1.
//  5. tx_ready=0, 25 pixels in -> 2 FIFO words plus a full pack register; ovf_error=1 after the 25th pixel.
//  6. Full 16x16 frame, then 16384 output pixels with tx_ready=1:
//     -> 2048 TX words, then frame_done and filt_reset each high for 1 cycle, FSM back to S_HDR.
//     -> Repeat with reset asserted mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/img_ctrl_pkg.sv
// Shared types and constants for the frame sequencer.
//   seq_state_e : frame sequencer FSM states
//   pixel_t     : one 8-bit image pixel
//   OUT_PIXELS  : output pixels per frame for the default output dimension
package img_ctrl_pkg;

  typedef enum logic [1:0] {S_HDR, S_LO, S_HI, S_DRAIN} seq_state_e;

  typedef logic [7:0] pixel_t;

  localparam int unsigned DEFAULT_OUT_DIM = 128;
  localparam int unsigned OUT_PIXELS      = DEFAULT_OUT_DIM * DEFAULT_OUT_DIM;

  // Saturate a signed filter result into the 0..255 pixel range.
  function automatic pixel_t clamp_pixel(input logic signed [31:0] v);
    if (v < 32'sd0) begin
      return 8'h00;
    end else if (v > 32'sd255) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// Two-entry 64-bit FIFO holding packed TX words.
//   clock, reset : system clock, synchronous active-high reset
//   push         : write push_data (taken when not full, or when popping)
//   push_data    : word to store
//   pop_ready    : consumer ready; head pops when pop_valid & pop_ready
//   pop_valid    : head entry valid
//   pop_data     : head entry
//   full, empty  : occupancy flags
module tx_word_fifo (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        pop_ready,
  output logic        pop_valid,
  output logic [63:0] pop_data,
  output logic        full,
  output logic        empty
);

  logic [63:0] mem_q [0:1];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        do_pop;
  logic        do_push;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);
  assign pop_valid = !empty;
  assign pop_data  = mem_q[rd_ptr_q];
  assign do_pop    = pop_valid && pop_ready;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Frame-level controller between the 64-bit RX/TX channels and the bicubic filter.
//   clock, reset        : system clock, synchronous active-high reset
//   rx_data/valid/ready : header word, then source pixels (8 per word)
//   rows, cols          : latched frame dimensions; info_valid marks an active frame
//   current_pixel_RAM   : highest source pixel index written, -1 when none
//   ram_wr_*            : write port shared by the 4 byte banks (pixel 4a+b in bank b)
//   filt_reset          : filter counter reset, pulsed at frame end
//   pixel_in/valid      : filter output pixels, no backpressure
//   tx_data/valid/ready : packed output words from a 2-entry FIFO
//   frame_done          : one-cycle end-of-frame pulse
//   hdr_error/ovf_error : sticky rejected-header / dropped-pixel flags
module frame_sequencer
  import img_ctrl_pkg::*;
#(
  parameter int unsigned MAX_PIXELS = 65536,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned OUT_DIM    = DEFAULT_OUT_DIM
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [63:0]        rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic signed [31:0] rows,
  output logic signed [31:0] cols,
  output logic               info_valid,
  output logic signed [31:0] current_pixel_RAM,
  output logic               ram_wr_en,
  output logic [ADDR_W-1:0]  ram_wr_addr,
  output pixel_t             ram_wr_data [0:3],
  output logic               filt_reset,
  input  logic signed [31:0] pixel_in,
  input  logic               pixel_valid,
  output logic [63:0]        tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               frame_done,
  output logic               hdr_error,
  output logic               ovf_error
);

  localparam int unsigned OutPixels = OUT_DIM * OUT_DIM;

  seq_state_e state_q, state_d;
  logic [31:0]        rows_q, cols_q, total_q, words_q, out_cnt_q;
  logic               info_valid_q;
  logic [ADDR_W-1:0]  addr_q, wr_addr_q;
  logic [31:0]        hi_q;
  logic               wr_en_q;
  pixel_t             wr_data_q [0:3];
  logic signed [31:0] cpr_q;
  logic [63:0]        pack_q, pack_d, push_data, word;
  logic [3:0]         cnt_q, cnt_d;
  logic               frame_done_q, filt_reset_q, hdr_err_q, ovf_q;

  logic        hdr_ok, rx_accept, push, drop, pix_acc, pop, can_push, frame_end;
  logic        fifo_full, fifo_empty;
  logic [33:0] prod;
  logic [31:0] words_total, fill, fill_clamped;

  // Header check; limiting each dimension first keeps the multiplier at 17x17.
  always_comb begin
    prod   = {17'b0, rx_data[16:0]} * {17'b0, rx_data[48:32]};
    hdr_ok = (rx_data[31:0] != 32'd0) && (rx_data[63:32] != 32'd0) &&
             (rx_data[31:0] <= MAX_PIXELS) && (rx_data[63:32] <= MAX_PIXELS) &&
             (prod <= 34'(MAX_PIXELS));
  end

  assign words_total  = (total_q + 32'd7) >> 3;
  assign fill         = ((32'(wr_addr_q) + 32'd1) << 2) - 32'd1;
  assign fill_clamped = (fill > total_q - 32'd1) ? total_q - 32'd1 : fill;
  assign frame_end    = info_valid_q && (out_cnt_q == OutPixels) && fifo_empty &&
                        (cnt_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    unique case (state_q)
      S_HDR: begin
        rx_ready = 1'b1;
        if (rx_valid && hdr_ok) state_d = S_LO;
      end
      S_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = S_HI;
      end
      S_HI:    state_d = (words_q + 32'd1 >= words_total) ? S_DRAIN : S_LO;
      S_DRAIN: state_d = S_DRAIN;
      default: state_d = S_HDR;
    endcase
    if (frame_end) state_d = S_HDR;
    if (reset) rx_ready = 1'b0;
  end

  assign rx_accept = rx_valid && rx_ready;

  // Output packing. cnt_q == 8 means a finished word is parked waiting for FIFO space.
  assign pix_acc  = pixel_valid && info_valid_q && (out_cnt_q < OutPixels);
  assign pop      = tx_valid && tx_ready;
  assign can_push = !fifo_full || pop;

  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    pack_d    = pack_q;
    cnt_d     = cnt_q;
    word      = pack_q;
    push_data = pack_q;
    if (cnt_q == 4'd8) begin
      if (can_push) begin
        push  = 1'b1;
        cnt_d = 4'd0;
        if (pix_acc) begin
          pack_d[7:0] = clamp_pixel(pixel_in);
          cnt_d       = 4'd1;
        end
      end else if (pix_acc) begin
        drop = 1'b1;
      end
    end else if (pix_acc) begin
      word[{cnt_q[2:0], 3'b000} +: 8] = clamp_pixel(pixel_in);
      pack_d = word;
      if (cnt_q == 4'd7) begin
        if (can_push) begin
          push      = 1'b1;
          push_data = word;
          cnt_d     = 4'd0;
        end else begin
          cnt_d = 4'd8;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_HDR;
      rows_q       <= '0;
      cols_q       <= '0;
      total_q      <= '0;
      words_q      <= '0;
      out_cnt_q    <= '0;
      info_valid_q <= 1'b0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      hi_q         <= '0;
      wr_en_q      <= 1'b0;
      for (int b = 0; b < 4; b++) wr_data_q[b] <= '0;
      cpr_q        <= -32'sd1;
      pack_q       <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      filt_reset_q <= 1'b1;
      hdr_err_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_end;
      filt_reset_q <= frame_end;
      wr_en_q      <= 1'b0;
      pack_q       <= pack_d;
      cnt_q        <= cnt_d;
      if (drop) ovf_q <= 1'b1;
      if (pix_acc) out_cnt_q <= out_cnt_q + 32'd1;
      if (wr_en_q) cpr_q <= $signed(fill_clamped);
      unique case (state_q)
        S_HDR: begin
          if (rx_accept && hdr_ok) begin
            rows_q       <= rx_data[31:0];
            cols_q       <= rx_data[63:32];
            total_q      <= prod[31:0];
            info_valid_q <= 1'b1;
            addr_q       <= '0;
            words_q      <= '0;
            out_cnt_q    <= '0;
          end else if (rx_accept) begin
            hdr_err_q <= 1'b1;
          end
        end
        S_LO: begin
          if (rx_accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            for (int b = 0; b < 4; b++) wr_data_q[b] <= rx_data[8*b +: 8];
            hi_q      <= rx_data[63:32];
          end
        end
        S_HI: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr_q + ADDR_W'(1);
          for (int b = 0; b < 4; b++) wr_data_q[b] <= hi_q[8*b +: 8];
          addr_q    <= addr_q + ADDR_W'(2);
          words_q   <= words_q + 32'd1;
        end
        default: ;
      endcase
      if (frame_end) begin
        info_valid_q <= 1'b0;
        cpr_q        <= -32'sd1;
      end
    end
  end

  tx_word_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop_ready (tx_ready),
    .pop_valid (tx_valid),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rows              = $signed(rows_q);
  assign cols              = $signed(cols_q);
  assign info_valid        = info_valid_q;
  assign current_pixel_RAM = cpr_q;
  assign ram_wr_en         = wr_en_q;
  assign ram_wr_addr       = wr_addr_q;
  assign ram_wr_data       = wr_data_q;
  assign filt_reset        = filt_reset_q;
  assign frame_done        = frame_done_q;
  assign hdr_error         = hdr_err_q;
  assign ovf_error         = ovf_q;

endmodule
